// File: rtl/pool_frame_sched_if.sv
// Handshake/bus bundle between the pool frame sequencer and its environment.
// Ports: start/hold/pool_out_valid in; read/pool/write strobes, busy/done/err out.
interface pool_frame_sched_if #(
  parameter int SRC_ADDR_W = 10,
  parameter int DST_ADDR_W = 8
);
  logic                  start;
  logic                  hold;
  logic                  src_rd_en;
  logic [SRC_ADDR_W-1:0] src_rd_addr;
  logic                  pool_valid_in;
  logic                  pool_out_valid;
  logic                  dst_wr_en;
  logic [DST_ADDR_W-1:0] dst_wr_addr;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, hold, pool_out_valid,
    input  src_rd_en, src_rd_addr, pool_valid_in,
    input  dst_wr_en, dst_wr_addr, busy, done, err
  );

  modport slave (
    input  start, hold, pool_out_valid,
    output src_rd_en, src_rd_addr, pool_valid_in,
    output dst_wr_en, dst_wr_addr, busy, done, err
  );
endinterface

// File: rtl/pool_frame_sched.sv
// Frame sequencer for the 2x2 max-pool: raster source reads, dest writes.
// Ports: clk, rst_n (async low), bus (slave): start/hold in, strobes/status out.
module pool_frame_sched #(
  parameter int IN_WIDTH      = 24,
  parameter int IN_HEIGHT     = 24,
  parameter int SRC_ADDR_W    = 10,
  parameter int DST_ADDR_W    = 8,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pool_frame_sched_if.slave  bus
);
  localparam int N_IN  = IN_WIDTH * IN_HEIGHT;
  localparam int N_OUT = N_IN / 4;
  localparam int TW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam int OW    = DST_ADDR_W + 1;

  localparam logic [SRC_ADDR_W-1:0] RD_LAST  = SRC_ADDR_W'(N_IN - 1);
  localparam logic [OW-1:0]         OUT_LAST = OW'(N_OUT - 1);
  localparam logic [OW-1:0]         OUT_FULL = OW'(N_OUT);
  localparam logic [TW-1:0]         TMO_LAST = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [SRC_ADDR_W-1:0] rd_cnt;
  logic [OW-1:0]         out_cnt;
  logic [TW-1:0]         tmo;

  // Writes are accepted in every non-idle state so the final pooled
  // output, which can land as DRAIN exits, is never dropped.
  assign bus.dst_wr_en   = bus.pool_out_valid & (state != IDLE);
  assign bus.dst_wr_addr = out_cnt[DST_ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rd_cnt            <= '0;
      out_cnt           <= '0;
      tmo               <= '0;
      bus.src_rd_en     <= 1'b0;
      bus.src_rd_addr   <= '0;
      bus.pool_valid_in <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      bus.src_rd_en     <= 1'b0;
      bus.done          <= 1'b0;
      bus.pool_valid_in <= bus.src_rd_en;

      if (bus.dst_wr_en) begin
        if (out_cnt == OUT_FULL) bus.err <= 1'b1;
        else out_cnt <= out_cnt + 1'b1;
      end

      if (bus.pool_out_valid && state == IDLE)
        bus.err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            bus.busy <= 1'b1;
            rd_cnt  <= '0;
            out_cnt <= '0;
            tmo     <= '0;
            bus.err <= 1'b0;
            // Issue pixel 0 on the accepting edge so the first read
            // lands one cycle after start.
            if (!bus.hold) begin
              bus.src_rd_en   <= 1'b1;
              bus.src_rd_addr <= '0;
              rd_cnt          <= SRC_ADDR_W'(1);
            end
          end
        end
        RUN: begin
          if (!bus.hold) begin
            bus.src_rd_en   <= 1'b1;
            bus.src_rd_addr <= rd_cnt;
            rd_cnt          <= rd_cnt + 1'b1;
            if (rd_cnt == RD_LAST) begin
              state <= DRAIN;
              tmo   <= '0;
            end
          end
        end
        DRAIN: begin
          if (bus.pool_out_valid) begin
            tmo <= '0;
            if (out_cnt == OUT_LAST) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end else if (tmo == TMO_LAST) begin
            bus.err  <= 1'b1;
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_frame_sched.sv
// Bench for pool_frame_sched with a behavioural 2x2 pool model.
// Ports: none; drives the sequencer through pool_frame_sched_if.
module tb_pool_frame_sched;
  localparam int W    = 24;
  localparam int H    = 24;
  localparam int N_IN = W * H;
  localparam int DT   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic force_ov;

  always #5 clk = ~clk;

  pool_frame_sched_if #(.SRC_ADDR_W(10), .DST_ADDR_W(8)) bus ();

  pool_frame_sched #(
    .IN_WIDTH(W), .IN_HEIGHT(H),
    .SRC_ADDR_W(10), .DST_ADDR_W(8),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int   prow, pcol, emit, limit;
  logic p_ov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prow <= 0;
      pcol <= 0;
      emit <= 0;
      p_ov <= 1'b0;
    end else begin
      p_ov <= 1'b0;
      if (bus.start && !bus.busy) emit <= 0;
      if (bus.pool_valid_in) begin
        pcol <= (pcol == W - 1) ? 0 : pcol + 1;
        if (pcol == W - 1) prow <= (prow == H - 1) ? 0 : prow + 1;
        if (prow[0] && pcol[0] && emit < limit) begin
          p_ov <= 1'b1;
          emit <= emit + 1;
        end
      end
    end
  end

  assign bus.pool_out_valid = p_ov | force_ov;

  typedef struct {
    int hold_mode;
    int lim;
    bit extra;
    int exp_done;
    int exp_wr;
    bit exp_err;
  } vec_t;

  vec_t tbl[6];
  int   rd_q[$];
  int   wr_q[$];
  int   tests, fails;
  int   cyc, reads, writes, done_cnt, done_cyc, held;
  logic prev_rd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic sample();
    if (rst_n) chk("pool_valid_in", 32'(bus.pool_valid_in), 32'(prev_rd));
    prev_rd = rst_n ? bus.src_rd_en : 1'b0;
    if (bus.src_rd_en) begin
      reads++;
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_extra: got addr %0d expected none", bus.src_rd_addr);
      end else chk("rd_addr", 32'(bus.src_rd_addr), 32'(rd_q.pop_front()));
    end
    if (bus.dst_wr_en) begin
      writes++;
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr_extra: got addr %0d expected none", bus.dst_wr_addr);
      end else chk("wr_addr", 32'(bus.dst_wr_addr), 32'(wr_q.pop_front()));
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sample();
  endtask

  task automatic prep(input int nrd, input int nwr);
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < nrd; i++) rd_q.push_back(i);
    for (int i = 0; i < nwr; i++) wr_q.push_back(i);
    reads = 0; writes = 0; done_cnt = 0; done_cyc = -1; held = 0;
  endtask

  task automatic run_frame(input vec_t v);
    int h1;
    h1 = 0;
    prep(N_IN, v.exp_wr);
    limit = v.lim;
    bus.hold = 1'b0;
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
    chk("busy_c1", 32'(bus.busy), 32'd1);
    chk("err_c1", 32'(bus.err), 32'd0);
    chk("rd_en_c1", 32'(bus.src_rd_en), 32'd1);
    while (done_cnt == 0 && cyc < 1500) begin
      bus.hold = 1'b0;
      if (v.hold_mode[0] && reads == 100 && h1 < 10) begin
        bus.hold = 1'b1;
        h1++;
      end
      if (v.hold_mode[1] && reads >= 120 && reads < 168 && cyc[0])
        bus.hold = 1'b1;
      if (bus.hold) held++;
      bus.start = v.extra && cyc == 49;
      step();
    end
    bus.hold = 1'b0;
    bus.start = 1'b0;
    if (done_cnt == 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done");
    end
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done + held));
    if (v.extra) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    repeat (4) step();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("read_count", 32'(reads), 32'(N_IN));
    chk("write_count", 32'(writes), 32'(v.exp_wr));
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("err_end", 32'(bus.err), 32'(v.exp_err));
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{hold_mode: 0, lim: 1000, extra: 0, exp_done: 579, exp_wr: 144, exp_err: 0};
    tbl[1] = '{hold_mode: 1, lim: 1000, extra: 0, exp_done: 579, exp_wr: 144, exp_err: 0};
    tbl[2] = '{hold_mode: 3, lim: 1000, extra: 0, exp_done: 579, exp_wr: 144, exp_err: 0};
    tbl[3] = '{hold_mode: 0, lim: 1000, extra: 1, exp_done: 579, exp_wr: 144, exp_err: 0};
    tbl[4] = '{hold_mode: 0, lim: 100, extra: 0, exp_done: N_IN + DT, exp_wr: 100, exp_err: 1};
    tbl[5] = '{hold_mode: 0, lim: 1000, extra: 0, exp_done: 579, exp_wr: 144, exp_err: 0};

    tests = 0; fails = 0; cyc = 0; prev_rd = 1'b0;
    limit = 1000;
    rst_n = 1'b0;
    force_ov = 1'b0;
    bus.start = 1'b0;
    bus.hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(bus.src_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.src_rd_addr), 32'd0);
    chk("rst_pvi", 32'(bus.pool_valid_in), 32'd0);
    chk("rst_wr_en", 32'(bus.dst_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.dst_wr_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    prep(0, 0);
    force_ov = 1'b1;
    #1;
    chk("idle_ov_wr_en", 32'(bus.dst_wr_en), 32'd0);
    step();
    force_ov = 1'b0;
    chk("idle_ov_err", 32'(bus.err), 32'd1);
    chk("idle_ov_busy", 32'(bus.busy), 32'd0);
    chk("idle_ov_writes", 32'(writes), 32'd0);

    prep(N_IN, 144);
    limit = 1000;
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
    chk("mid_err_clr", 32'(bus.err), 32'd0);
    while (cyc < 300) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", 32'(bus.src_rd_en), 32'd0);
    chk("arst_rd_addr", 32'(bus.src_rd_addr), 32'd0);
    chk("arst_pvi", 32'(bus.pool_valid_in), 32'd0);
    chk("arst_wr_addr", 32'(bus.dst_wr_addr), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    chk("post_rst_rd", 32'(bus.src_rd_en), 32'd0);
    run_frame(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool_frame_sched.md
Name: pool_frame_sched

Overview:
Frame sequencer for the 2x2 six-channel max-pool stage. On a start pulse it reads one conv1 feature-map frame out of the source buffer in raster order and drives the pool's valid_in. It counts the pooled outputs and generates destination buffer write enables and addresses. It signals done when the frame is complete. The pool counters always see whole frames, so they return to row 0 / col 0 between frames.

Parameters:
IN_WIDTH, 24, frame width in pixels (even)
IN_HEIGHT, 24, frame height in pixels (even)
SRC_ADDR_W, 10, source buffer address width; must hold IN_WIDTH*IN_HEIGHT-1
DST_ADDR_W, 8, destination address width; must hold (IN_WIDTH/2)*(IN_HEIGHT/2)-1
DRAIN_TIMEOUT, 8, maximum cycles to wait for a pooled output in DRAIN

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle frame start request; ignored unless IDLE
hold  in  1  stalls new source reads while high; in-flight data still completes
src_rd_en  out  1  source buffer read enable; read data appears one cycle later
src_rd_addr  out  SRC_ADDR_W  source read address, raster index
pool_valid_in  out  1  to max-pool valid_in; equals src_rd_en delayed by one cycle
pool_out_valid  in  1  from max-pool out_valid
dst_wr_en  out  1  destination write enable
dst_wr_addr  out  DST_ADDR_W  destination write address
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the frame is complete
err  out  1  sticky error flag; cleared by an accepted start

Behaviour:
- Constants: N_IN = IN_WIDTH*IN_HEIGHT = 576; N_OUT = N_IN/4 = 144.
- Reset values: all outputs 0; state IDLE; rd_cnt, out_cnt and timeout counter 0.
- States:
  - IDLE: start=1 clears rd_cnt, out_cnt and err, then goes to RUN.
  - RUN: each cycle with hold=0, src_rd_en=1, src_rd_addr=rd_cnt, and rd_cnt increments. When the read at rd_cnt=N_IN-1 issues, go to DRAIN. hold=1 gives src_rd_en=0 and no counter change.
  - DRAIN: hold is ignored. pool_out_valid with out_cnt=N_OUT-1 goes to DONE. The timeout counter resets on every pool_out_valid and increments otherwise. Reaching DRAIN_TIMEOUT sets err and goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- src_rd_en and src_rd_addr are registered. pool_valid_in is src_rd_en registered once more.
- dst_wr_en = pool_out_valid while state is RUN, DRAIN or DONE (combinational). dst_wr_addr = out_cnt (registered). out_cnt increments on each dst_wr_en.
- Pooled channel data goes directly from the pool outputs to the destination buffer. This block handles only addresses and enables.
- Latency with no hold, start sampled at cycle 0:
  - first src_rd_en at cycle 1; last at cycle 576;
  - first pool_out_valid at cycle 28;
  - done at cycle 579; busy high for cycles 1..579.
- err is set by any of:
  - pool_out_valid while IDLE (no write is issued);
  - pool_out_valid when out_cnt is already N_OUT;
  - DRAIN timeout.
- start while busy is ignored, with no effect on counters or err.
- start and hold both high in IDLE: go to RUN. The first read waits until hold falls.
- Reset asserted mid-frame returns every output to 0 immediately. The pool must share the same rst_n so its row/col counters clear together with this block.

Test Plan:
- Single frame, hold=0, pool behavioural model attached: exactly 576 reads at addresses 0..575 in cycles 1..576; 144 writes at addresses 0..143; done pulses once at cycle 579.
- hold held high for 10 cycles at rd_cnt=100, and again on every other cycle during rows 5-6: addresses stay contiguous with no duplicates; write count is still 144; done is delayed by exactly the number of held cycles.
- start pulsed at cycles 50 and 579 during a frame: both are ignored; one done; a second start after done runs a clean second frame, and the pool output matches the golden model for both frames.
- Pool model stops emitting after 100 outputs: DRAIN times out after DRAIN_TIMEOUT idle cycles; err=1; done pulses; next start clears err.
- pool_out_valid forced high for one cycle in IDLE: err=1, dst_wr_en=0.
- rst_n pulsed low at cycle 300: all outputs 0 asynchronously, state IDLE; a following frame completes correctly with 144 writes.
